// File: rtl/bsh_pkg.sv
// rtl/bsh_pkg.sv - shared state enum, direction codes and default sizes for the de-rotator
package bsh_pkg;

  localparam int BSH_WIDTH = 32;
  localparam int BSH_SHW   = 5;

  // Direction encoding shared with the forward barrel rotator
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bsh_state_t;

endpackage

// File: rtl/bsh_rot_step.sv
// rtl/bsh_rot_step.sv - combinational rotate of a word by 0..STEP bits left or right
module bsh_rot_step
  import bsh_pkg::*;
#(
  parameter int WIDTH = BSH_WIDTH,
  parameter int SHW   = BSH_SHW,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
  input  logic [SHW-1:0]   amt,
  output logic [WIDTH-1:0] result
);

  // Small mux over the STEP+1 possible amounts; amt=0 passes the word through
  always_comb begin
    result = data;
    for (int i = 1; i <= STEP; i++) begin
      if (amt == SHW'(i)) begin
        if (dir == DIR_RIGHT) begin
          result = (data >> i) | (data << (WIDTH - i));
        end else begin
          result = (data << i) | (data >> (WIDTH - i));
        end
      end
    end
  end

endmodule

// File: rtl/bsh_derot_seq.sv
// rtl/bsh_derot_seq.sv - multi-cycle inverse rotator; BSH_DEROT_CNT_EN adds the op_cnt handshake counter
module bsh_derot_seq
  import bsh_pkg::*;
#(
  parameter int WIDTH = BSH_WIDTH,
  parameter int SHW   = BSH_SHW,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir,
  input  logic [SHW-1:0]   sh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out
`ifdef BSH_DEROT_CNT_EN
  ,
  output logic [15:0]      op_cnt
`endif
);

  localparam logic [SHW-1:0] STEP_AMT = SHW'(STEP);

  bsh_state_t       state;
  bsh_state_t       next_state;
  logic [WIDTH-1:0] work;
  logic             dir_q;
  logic [SHW-1:0]   rem;
  logic [SHW-1:0]   k;
  logic [SHW-1:0]   rem_next;
  logic [WIDTH-1:0] rot_out;

  // Never rotate past the remaining amount, so rem cannot underflow
  assign k        = (rem < STEP_AMT) ? rem : STEP_AMT;
  assign rem_next = rem - k;

  // Undo the forward rotation by turning the opposite way (left<->right)
  bsh_rot_step #(
    .WIDTH (WIDTH),
    .SHW   (SHW),
    .STEP  (STEP)
  ) u_rot_step (
    .data   (work),
    .dir    (~dir_q),
    .amt    (k),
    .result (rot_out)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs; only IDLE accepts, only DONE presents
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = (sh == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (rem_next == '0) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Working register, remaining count, and result capture on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work     <= '0;
      dir_q    <= 1'b0;
      rem      <= '0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= data_in;
            dir_q <= dir;
            rem   <= sh;
            if (sh == '0) begin
              data_out <= data_in;
            end
          end
        end
        RUN: begin
          work <= rot_out;
          rem  <= rem_next;
          if (rem_next == '0) begin
            data_out <= rot_out;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BSH_DEROT_CNT_EN
  // Saturating count of completed output handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt <= '0;
    end else if (out_valid && out_ready && (op_cnt != 16'hFFFF)) begin
      op_cnt <= op_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/bsh_derot_seq.md
Name: bsh_derot_seq

Overview:
- Multi-cycle inverse rotator: restores the original word from a word produced by the combinational 32-bit barrel rotator, given that rotator's dir/sh.
- Rotates opposite to the recorded direction, STEP bits per cycle.
- Sits on the receive/decode side of the rotate path; valid/ready on both ends.
- Trades latency for area versus a full barrel stage.

Parameters:
- WIDTH, 32, data word width.
- SHW, 5, shift-amount width; must equal log2(WIDTH).
- STEP, 1, max bits rotated per cycle; power of 2, 1..WIDTH/2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input word/dir/sh valid.
- in_ready  out  1  block can accept.
- data_in  in  WIDTH  rotated word to restore.
- dir  in  1  direction used by the forward rotation: 0 = left, 1 = right.
- sh  in  SHW  forward rotation amount.
- out_valid  out  1  restored word valid.
- out_ready  in  1  downstream accepts.
- data_out  out  WIDTH  restored word.

Behaviour:
- Function: data_out = data_in rotated by sh in the direction opposite to dir.
  - dir=0: rotate right by sh.
  - dir=1: rotate left by sh.
  - Rotation is modulo WIDTH; sh=0 gives identity.
- Reset (async assert, any state): state=IDLE, in_ready=1, out_valid=0, data_out=0, remaining-count=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid, capture data_in, dir, sh.
    - rem=sh.
    - Go to RUN if sh!=0, else go to DONE.
  - RUN: in_ready=0. Each cycle rotate the working register by k=min(rem,STEP) in the inverse direction; rem -= k. When rem reaches 0, go to DONE.
  - DONE: out_valid=1, data_out=working register. On out_ready, go to IDLE and drop out_valid.
- Latency: out_valid is asserted ceil(sh/STEP)+1 cycles after the accept edge.
  - sh=0: out_valid in the cycle after accept.
  - No back-to-back accept: in_ready is asserted only in IDLE, so throughput is one word per latency+1+stall cycles.
- Inputs are sampled only on the accept edge; later changes to data_in/dir/sh are ignored.
- in_valid while not in IDLE: ignored, no capture.
- out_ready while not in DONE: ignored.
- Back-pressure: in DONE with out_ready=0, data_out and out_valid hold stable indefinitely.
- data_out holds its last value in IDLE/RUN; it is not required to be meaningful when out_valid=0.
- Reset mid-RUN or mid-DONE: the operation is discarded with no output; the block restarts in IDLE after release.
- Width: rem is SHW bits and never underflows because k<=rem. Per-cycle rotate is a small mux over 0..STEP.

Optional Feature:
- Macro BSH_DEROT_CNT_EN.
- Defined: adds output port op_cnt, out, 16 bits.
  - Counts completed output handshakes (out_valid & out_ready).
  - Saturates at 0xFFFF; async reset to 0.
- Undefined: no op_cnt port and no counter logic; behaviour is otherwise identical.

Decomposition:
- Shared package bsh_pkg:
  - State enum {IDLE, RUN, DONE}.
  - DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
  - Default WIDTH/SHW constants.
- One sub-module, bsh_rot_step: combinational rotate of WIDTH bits by 0..STEP in a given direction, instantiated once on the working register.

Test Plan:
- STEP=1, data_in=0x0000_0010, dir=0, sh=4 -> data_out=0x0000_0001; out_valid 5 cycles after accept.
- sh=0, data_in=0xDEAD_BEEF, dir=1 -> data_out=0xDEAD_BEEF; out_valid the cycle after accept.
- STEP=1, data_in=0x0000_0003, dir=1, sh=31 -> left rotate 31 -> data_out=0x8000_0001 after 32 cycles.
- STEP=4, data_in=0x0000_0080, dir=0, sh=7 -> data_out=0x0000_0001; RUN lasts 2 cycles (k=4 then 3).
- Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new data -> data_out/out_valid stable, in_ready=0, no capture; then out_ready=1 -> IDLE, in_ready=1.
- Assert rst in the 3rd RUN cycle of an sh=8 op -> out_valid=0, data_out=0, in_ready=1 immediately.
  - With BSH_DEROT_CNT_EN, after 3 completed ops then reset: op_cnt=3, then 0.
